// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the APB 8-bit timer.
//   TIMER_WIDTH       default counter/data width
//   TCR_* / TSR_*     bit positions inside the control and status registers
package timer_pkg;

  localparam int TIMER_WIDTH = 8;

  // TCR layout
  localparam int TCR_CKS_LSB = 0;
  localparam int TCR_EN      = 4;
  localparam int TCR_DIR     = 5;
  localparam int TCR_LOAD    = 7;

  // TSR layout
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

endpackage

// File: rtl/timer_edge_detect.sv
// timer_edge_detect: rising-edge strobe for a level that already lives in the
// PCLK domain. Also intended for external-event counting.
// Ports:
//   PCLK    in   system clock
//   PRESET  in   synchronous active-high reset
//   sig_in  in   level to watch
//   rise    out  combinational strobe, high for one PCLK per rising edge of sig_in
module timer_edge_detect (
  input  logic PCLK,
  input  logic PRESET,
  input  logic sig_in,
  output logic rise
);

  logic clk_d_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) clk_d_q <= 1'b0;
    else        clk_d_q <= sig_in;
  end

  assign rise = sig_in & ~clk_d_q;

endmodule

// File: rtl/timer_counter.sv
// timer_counter: counting core of the APB 8-bit timer. Advances TCNT once per
// rising edge of the prescaled level clk_in; supports up/down counting,
// parallel load from TDR and sticky overflow/underflow flags.
// Build option: define TIMER_AUTO_RELOAD_EN to make a wrap reload TDR instead
// of 0 (up) / all-ones (down). Flags and load behave the same in both builds.
// Ports:
//   PCLK     in   system clock
//   PRESET   in   synchronous active-high reset
//   clk_in   in   prescaled clock level
//   TCR      in   control: [4] en, [5] dir (1=down), [7] load; others ignored
//   TDR      in   load / reload value
//   ovf_clr  in   one-cycle clear of ovf
//   udf_clr  in   one-cycle clear of udf
//   TCNT     out  current count (registered)
//   ovf      out  sticky overflow flag
//   udf      out  sticky underflow flag
//   tick     out  combinational rising-edge strobe of clk_in
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             clk_in,
  input  logic [7:0]       TCR,
  input  logic [WIDTH-1:0] TDR,
  input  logic             ovf_clr,
  input  logic             udf_clr,
  output logic [WIDTH-1:0] TCNT,
  output logic             ovf,
  output logic             udf,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] tcnt_q, tcnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             ovf_set, udf_set;
  logic [WIDTH-1:0] wrap_up, wrap_dn;
  logic             en, dir, load;

  // Clock-select and reserved bits are consumed upstream.
  logic unused_tcr;
  assign unused_tcr = ^{TCR[TCR_CKS_LSB +: 2], TCR[3:2], TCR[6]};

  assign en   = TCR[TCR_EN];
  assign dir  = TCR[TCR_DIR];
  assign load = TCR[TCR_LOAD];

`ifdef TIMER_AUTO_RELOAD_EN
  assign wrap_up = TDR;
  assign wrap_dn = TDR;
`else
  assign wrap_up = '0;
  assign wrap_dn = ALL_ONES;
`endif

  timer_edge_detect u_edge (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .sig_in (clk_in),
    .rise   (tick)
  );

  always_comb begin
    tcnt_d  = tcnt_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (load) begin
      // Load swallows any coincident tick and never raises a flag.
      tcnt_d = TDR;
    end else if (en && tick) begin
      if (!dir) begin
        if (tcnt_q == ALL_ONES) begin
          tcnt_d  = wrap_up;
          ovf_set = 1'b1;
        end else begin
          tcnt_d = tcnt_q + ONE;
        end
      end else begin
        if (tcnt_q == '0) begin
          tcnt_d  = wrap_dn;
          udf_set = 1'b1;
        end else begin
          tcnt_d = tcnt_q - ONE;
        end
      end
    end
  end

  // Set beats a coincident clear so a wrap is never lost to a racing W1C.
  assign ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  assign udf_d = udf_set | (udf_q & ~udf_clr);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tcnt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign TCNT = tcnt_q;
  assign ovf  = ovf_q;
  assign udf  = udf_q;

endmodule
